// File: rtl/ysyx_25040101_csr_defs.sv
// Shared definitions for the machine-mode CSR file.
// Covers CSR addresses, mstatus bit positions, the ecall cause code and the
// identification constants returned by the read-only CSRs.
package ysyx_25040101_csr_defs;

  typedef logic [11:0] csr_addr_t;

  // Read/write CSRs
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;

  // Read-only identification CSRs
  localparam csr_addr_t CSR_MVENDORID = 12'hF11;
  localparam csr_addr_t CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL   = 32'h017E_14E5;

  // mstatus field positions; only these bits carry state
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Machine-mode only core: MPP always reads as M
  localparam logic [1:0] MPP_MACHINE = 2'b11;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  // Which control-flow event wins this cycle; ecall outranks mret
  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_ECALL = 2'd1,
    EVT_MRET  = 2'd2
  } csr_event_e;

  // Rebuild the architectural mstatus word from the stored bits
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = '0;
    v[MSTATUS_MIE]                   = mie;
    v[MSTATUS_MPIE]                  = mpie;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_MACHINE;
    return v;
  endfunction

  // Clear the two low bits (word alignment for mtvec/mepc)
  function automatic logic [31:0] align4(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ysyx_25040101_csr_file_if.sv
// Bus between the execute/result stage (master) and the CSR file (slave).
//
// Handshake semantics: there is no ready/backpressure. Every request field
// (csr_addr_i, csr_we_i, csr_wdata_i, ecall_i, mret_i, pc_i) describes the
// instruction retiring in the current cycle and is consumed at the next rising
// clock edge. csr_rdata_o/csr_illegal_o answer csr_addr_i in the same cycle.
// redirect_valid_o is a valid-only strobe: when high, fetch must take
// redirect_pc_o in this cycle; it cannot be stalled.
interface ysyx_25040101_csr_file_if;
  import ysyx_25040101_csr_defs::*;

  csr_addr_t   csr_addr_i;
  logic        csr_we_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        ecall_i;
  logic        mret_i;
  logic [31:0] pc_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output csr_addr_i, csr_we_i, csr_wdata_i, ecall_i, mret_i, pc_i,
    input  csr_rdata_o, csr_illegal_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  csr_addr_i, csr_we_i, csr_wdata_i, ecall_i, mret_i, pc_i,
    output csr_rdata_o, csr_illegal_o, redirect_valid_o, redirect_pc_o
  );

endinterface

// File: rtl/ysyx_25040101_csr_cycle_counter.sv
// Free-running 64-bit mcycle counter.
// A write to either half replaces that half and suppresses the increment for
// that cycle, so a pending low-half carry is never applied on top of a write.
module ysyx_25040101_csr_cycle_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  // Count every cycle unless software is replacing one of the halves
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= 64'd0;
    end else if (wr_lo_i) begin
      count_o[31:0] <= wdata_i;
    end else if (wr_hi_i) begin
      count_o[63:32] <= wdata_i;
    end else begin
      count_o <= count_o + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_25040101_csr_file.sv
// Machine-mode CSR register file.
// Holds mstatus (MIE/MPIE only), mtvec, mepc, mcause and mcycle. Reads are
// combinational and show the pre-edge value; writes, trap entry and mret
// commit at the next rising edge. ecall > mret > CSR write, and a losing
// event is dropped entirely.
module ysyx_25040101_csr_file
  import ysyx_25040101_csr_defs::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input logic                          clk_i,
  input logic                          rst_i,
  ysyx_25040101_csr_file_if.slave      bus
);

  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [63:0] mcycle;

  csr_event_e  evt;
  logic [31:0] rdata;
  logic        known;
  logic        read_only;
  logic        csr_wr;
  logic        wr_lo;
  logic        wr_hi;
  logic [31:0] redirect_pc;
  logic        redirect_valid;

  // Resolve the retiring control-flow event by priority
  always_comb begin
    evt = EVT_NONE;
    if (bus.ecall_i) begin
      evt = EVT_ECALL;
    end else if (bus.mret_i) begin
      evt = EVT_MRET;
    end
  end

  // Read mux and address decode; unimplemented addresses read as zero
  always_comb begin
    rdata     = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (bus.csr_addr_i)
      CSR_MSTATUS:   rdata = mstatus_pack(mie, mpie);
      CSR_MTVEC:     rdata = mtvec;
      CSR_MEPC:      rdata = mepc;
      CSR_MCAUSE:    rdata = mcause;
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MVENDORID: begin
        rdata     = MVENDORID_VAL;
        read_only = 1'b1;
      end
      CSR_MARCHID:   begin
        rdata     = MARCHID_VAL;
        read_only = 1'b1;
      end
      default:       known = 1'b0;
    endcase
  end

  // A write lands only when no trap/return claims the cycle and the target is writable
  assign csr_wr = bus.csr_we_i && (evt == EVT_NONE) && known && !read_only;
  assign wr_lo  = csr_wr && (bus.csr_addr_i == CSR_MCYCLE);
  assign wr_hi  = csr_wr && (bus.csr_addr_i == CSR_MCYCLEH);

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = !known || (bus.csr_we_i && read_only);

  // Redirect target straight from the stored vectors; no bypass of same-cycle writes
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (evt)
      EVT_ECALL: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec;
      end
      EVT_MRET: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
      end
      default: begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
      end
    endcase
  end

  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;

  // Commit trap entry, trap return or a software CSR write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mtvec  <= align4(MTVEC_RESET);
      mepc   <= 32'd0;
      mcause <= 32'd0;
    end else begin
      case (evt)
        EVT_ECALL: begin
          mepc   <= align4(bus.pc_i);
          mcause <= MCAUSE_ECALL_M;
          mpie   <= mie;
          mie    <= 1'b0;
        end
        EVT_MRET: begin
          mie  <= mpie;
          mpie <= 1'b1;
        end
        default: begin
          if (csr_wr) begin
            case (bus.csr_addr_i)
              CSR_MSTATUS: begin
                mie  <= bus.csr_wdata_i[MSTATUS_MIE];
                mpie <= bus.csr_wdata_i[MSTATUS_MPIE];
              end
              CSR_MTVEC:  mtvec  <= align4(bus.csr_wdata_i);
              CSR_MEPC:   mepc   <= align4(bus.csr_wdata_i);
              CSR_MCAUSE: mcause <= bus.csr_wdata_i;
              default:    ;
            endcase
          end
        end
      endcase
    end
  end

  ysyx_25040101_csr_cycle_counter u_cycle_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_lo_i (wr_lo),
    .wr_hi_i (wr_hi),
    .wdata_i (bus.csr_wdata_i),
    .count_o (mcycle)
  );

endmodule

// File: tb/tb_ysyx_25040101_csr_file.sv
// Self-checking bench for the machine-mode CSR file.
module tb_ysyx_25040101_csr_file;

  localparam int W = 66;  // {rdata[31:0], illegal, redirect_valid, redirect_pc[31:0]}

  logic clk;
  logic rst;

  ysyx_25040101_csr_file_if bus();

  ysyx_25040101_csr_file #(
    .MTVEC_RESET (32'h0000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] obs_rdata;
  logic        obs_illegal;
  logic        obs_rvalid;
  logic [31:0] obs_rpc;

  // Reference model of the architectural CSR state
  logic        m_mie;
  logic        m_mpie;
  logic [31:0] m_mtvec;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [63:0] m_cycle;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mie    = 1'b0;
    m_mpie   = 1'b0;
    m_mtvec  = 32'h0;
    m_mepc   = 32'h0;
    m_mcause = 32'h0;
    m_cycle  = 64'h0;
  endtask

  // Returns {illegal, rdata}
  function automatic logic [32:0] model_read(input logic [11:0] a, input logic we);
    case (a)
      12'h300: return {1'b0, 32'h0000_1800 | {24'h0, m_mpie, 3'b000, m_mie, 3'b000}};
      12'h305: return {1'b0, m_mtvec};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'hB00: return {1'b0, m_cycle[31:0]};
      12'hB80: return {1'b0, m_cycle[63:32]};
      12'hF11: return {we, 32'h7973_7978};
      12'hF12: return {we, 32'h017E_14E5};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic model_commit(input logic [11:0] a, input logic we, input logic [31:0] wd,
                              input logic ec, input logic mr, input logic [31:0] pc);
    logic [63:0] nc;
    logic        old_mie;
    nc = m_cycle + 64'd1;
    if (ec) begin
      old_mie  = m_mie;
      m_mepc   = {pc[31:2], 2'b00};
      m_mcause = 32'd11;
      m_mpie   = old_mie;
      m_mie    = 1'b0;
    end else if (mr) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
    end else if (we) begin
      case (a)
        12'h300: begin
          m_mie  = wd[3];
          m_mpie = wd[7];
        end
        12'h305: m_mtvec  = {wd[31:2], 2'b00};
        12'h341: m_mepc   = {wd[31:2], 2'b00};
        12'h342: m_mcause = wd;
        12'hB00: nc = {m_cycle[63:32], wd};
        12'hB80: nc = {wd, m_cycle[31:0]};
        default: ;
      endcase
    end
    m_cycle = nc;
  endtask

  // ---------------- driver ----------------
  // Drive one retiring instruction, push its expected response, compare at negedge
  task automatic cycle(input logic [11:0] a, input logic we, input logic [31:0] wd,
                       input logic ec, input logic mr, input logic [31:0] pc);
    logic [32:0]  r;
    logic [W-1:0] e;
    bus.csr_addr_i  = a;
    bus.csr_we_i    = we;
    bus.csr_wdata_i = wd;
    bus.ecall_i     = ec;
    bus.mret_i      = mr;
    bus.pc_i        = pc;
    r = model_read(a, we);
    e = {r[31:0], r[32], ec | mr, ec ? m_mtvec : (mr ? m_mepc : 32'h0)};
    exp_q.push_back(e);
    @(negedge clk);
    obs_rdata   = bus.csr_rdata_o;
    obs_illegal = bus.csr_illegal_o;
    obs_rvalid  = bus.redirect_valid_o;
    obs_rpc     = bus.redirect_pc_o;
    e = exp_q.pop_front();
    check_eq($sformatf("rdata@%03h", a), {32'h0, obs_rdata}, {32'h0, e[65:34]});
    check_eq($sformatf("illegal@%03h", a), {63'h0, obs_illegal}, {63'h0, e[33]});
    check_eq("redirect_valid", {63'h0, obs_rvalid}, {63'h0, e[32]});
    check_eq("redirect_pc", {32'h0, obs_rpc}, {32'h0, e[31:0]});
    model_commit(a, we, wd, ec, mr, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    cycle(a, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd);
    cycle(a, 1'b1, wd, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [11:0] addr_tab[10];

  initial begin
    addr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00,
                 12'hB80, 12'hF11, 12'hF12, 12'h7C0, 12'h344};
    rst             = 1'b1;
    bus.csr_addr_i  = 12'h300;
    bus.csr_we_i    = 1'b0;
    bus.csr_wdata_i = 32'h0;
    bus.ecall_i     = 1'b0;
    bus.mret_i      = 1'b0;
    bus.pc_i        = 32'h0;
    model_reset();

    #1;
    check_eq("in_reset_mstatus", {32'h0, bus.csr_rdata_o}, 64'h1800);
    check_eq("in_reset_rvalid", {63'h0, bus.redirect_valid_o}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values and counter start
    rd(12'hB00);  check_eq("tp_mcycle_first", {32'h0, obs_rdata}, 64'h0);
    rd(12'hB00);  check_eq("tp_mcycle_second", {32'h0, obs_rdata}, 64'h1);
    rd(12'h300);  check_eq("tp_mstatus_rst", {32'h0, obs_rdata}, 64'h1800);
    rd(12'h305);  check_eq("tp_mtvec_rst", {32'h0, obs_rdata}, 64'h0);
    rd(12'hF11);  check_eq("tp_mvendorid", {32'h0, obs_rdata}, 64'h7973_7978);
    rd(12'hF12);  check_eq("tp_marchid", {32'h0, obs_rdata}, 64'h017E_14E5);
    rd(12'h7C0);
    check_eq("tp_unimpl_rdata", {32'h0, obs_rdata}, 64'h0);
    check_eq("tp_unimpl_illegal", {63'h0, obs_illegal}, 64'h1);

    // mtvec write then ecall
    wr(12'h305, 32'h8000_0103);
    cycle(12'h305, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0046);
    check_eq("tp_ecall_redirect", {32'h0, obs_rpc}, 64'h8000_0100);
    rd(12'h341);  check_eq("tp_mepc", {32'h0, obs_rdata}, 64'h8000_0044);
    rd(12'h342);  check_eq("tp_mcause", {32'h0, obs_rdata}, 64'd11);
    rd(12'h300);  check_eq("tp_mie_clear", {32'h0, obs_rdata}, 64'h1800);

    // MIE -> ecall -> mret
    wr(12'h300, 32'h0000_0008);
    cycle(12'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0200);
    rd(12'h300);  check_eq("tp_mpie_set", {32'h0, obs_rdata}, 64'h1880);
    cycle(12'h341, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    check_eq("tp_mret_redirect", {32'h0, obs_rpc}, 64'h8000_0200);
    rd(12'h300);  check_eq("tp_mret_mstatus", {32'h0, obs_rdata}, 64'h1888);

    // mcycle low-half write and carry
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00);  check_eq("tp_mcycle_written", {32'h0, obs_rdata}, 64'hFFFF_FFFF);
    rd(12'hB00);  check_eq("tp_mcycle_wrap_lo", {32'h0, obs_rdata}, 64'h0);
    rd(12'hB80);  check_eq("tp_mcycle_carry_hi", {32'h0, obs_rdata}, 64'h1);

    // ecall + mret + write together: only ecall applies
    cycle(12'h341, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h8000_0313);
    check_eq("tp_prio_redirect", {32'h0, obs_rpc}, 64'h8000_0100);
    rd(12'h341);  check_eq("tp_prio_mepc", {32'h0, obs_rdata}, 64'h8000_0310);

    // mret with same-cycle mepc write: old mepc used, write dropped
    cycle(12'h341, 1'b1, 32'h0000_5554, 1'b0, 1'b1, 32'h0);
    check_eq("tp_mret_old_mepc", {32'h0, obs_rpc}, 64'h8000_0310);
    rd(12'h341);  check_eq("tp_mret_drop_wr", {32'h0, obs_rdata}, 64'h8000_0310);

    // Write to read-only CSR
    wr(12'hF11, 32'h0);
    check_eq("tp_ro_illegal", {63'h0, obs_illegal}, 64'h1);
    rd(12'hF11);  check_eq("tp_ro_unchanged", {32'h0, obs_rdata}, 64'h7973_7978);

    // mcycleh write
    wr(12'hB80, 32'h0000_00AB);
    rd(12'hB80);  check_eq("tp_mcycleh_wr", {32'h0, obs_rdata}, 64'hAB);

    // Mixed random traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [11:0] a;
      logic        we;
      logic        ec;
      logic        mr;
      a  = addr_tab[$urandom_range(0, 9)];
      we = ($urandom_range(0, 1) == 1);
      ec = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 7) == 0);
      cycle(a, we, $urandom, ec, mr, $urandom);
    end

    // Asynchronous reset mid-run
    cycle(12'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0400);
    rd(12'h341);  check_eq("pre_rst_mepc", {32'h0, obs_rdata}, 64'h8000_0400);
    bus.csr_addr_i = 12'hB00;
    bus.csr_we_i   = 1'b0;
    bus.ecall_i    = 1'b0;
    bus.mret_i     = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_async_mcycle", {32'h0, bus.csr_rdata_o}, 64'h0);
    bus.csr_addr_i = 12'h341;
    #1;
    check_eq("rst_async_mepc", {32'h0, bus.csr_rdata_o}, 64'h0);
    rst = 1'b0;
    model_reset();
    rd(12'hB00);  check_eq("post_rst_mcycle", {32'h0, obs_rdata}, 64'h0);
    rd(12'h305);
    rd(12'h300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25040101_csr_file.md
# ysyx_25040101_csr_file

Machine-mode CSR register file that answers the CSR read/write traffic issued by the ALU result stage, which forwards the old CSR value to rd and supplies the new value for csrrw/csrrs. It holds mstatus, mtvec, mepc, mcause and a free-running 64-bit mcycle. It returns read data combinationally, commits writes on the clock edge, and performs ecall trap entry and mret return, including the PC redirect to fetch. It sits beside the execute stage in the single-issue nebula-core-B datapath.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec
- clk_i  in  1  core clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- csr_addr_i  in  12  CSR address for both read and write of the current instruction
- csr_we_i  in  1  commit csr_wdata_i to csr_addr_i at the next edge
- csr_wdata_i  in  32  new CSR value computed by the ALU
- csr_rdata_o  out  32  current value of csr_addr_i, combinational
- csr_illegal_o  out  1  csr_addr_i unimplemented, or write to a read-only CSR, combinational
- ecall_i  in  1  ecall retiring this cycle
- mret_i  in  1  mret retiring this cycle
- pc_i  in  32  PC of the retiring instruction
- redirect_valid_o  out  1  fetch must jump to redirect_pc_o, combinational
- redirect_pc_o  out  32  trap or return target, combinational

## Operation
- Implemented CSRs (read/write): mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80.
- Implemented CSRs (read-only): mvendorid 0xF11 = 32'h7973_7978, marchid 0xF12 = 32'h017E_14E5.
- Unimplemented address: csr_rdata_o = 0, csr_illegal_o = 1, and the write is dropped.
- mstatus storage: only MIE[3], MPIE[7] and MPP[12:11] are stored. MPP is hardwired to 2'b11. All other bits read 0 and are write-ignored.
- Write masks:
  - mtvec: bits [1:0] forced to 0 (direct mode only).
  - mepc: bits [1:0] forced to 0.
  - mcause: full 32-bit write.
- mcycle increments by 1 every cycle as a 64-bit counter. It wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A CSR write to mcycle or mcycleh replaces that half, and the whole counter does not increment in that cycle. The carry from a low-half increment is therefore never applied after a write.
- ecall:
  - mepc ← pc_i & ~3; mcause ← 32'd11; MPIE ← MIE; MIE ← 0.
  - redirect_pc_o = mtvec; redirect_valid_o = 1.
- mret:
  - MIE ← MPIE; MPIE ← 1.
  - redirect_pc_o = mepc; redirect_valid_o = 1.
- Priority on simultaneous events: ecall > mret > csr_we_i.
  - A lower-priority event in the same cycle is fully dropped; no partial update.
  - mcycle still increments.
- No event: redirect_valid_o = 0, redirect_pc_o = 0.

## Timing
- Reset (async assert, state cleared immediately):
  - mstatus = 32'h0000_1800; mtvec = MTVEC_RESET & ~3; mepc = 0; mcause = 0; mcycle = 0.
  - Outputs follow the reset state: csr_rdata_o reflects csr_addr_i; redirect_valid_o = 0 unless ecall_i/mret_i are high.
- Reset deassertion: mcycle reads 0 in the first cycle after deassertion and 1 in the next.
- Reads have 0-cycle latency. csr_rdata_o shows the pre-edge value, so csrrw returns the old value while the new value is written at the same edge.
- Writes, trap entry and mret take effect at the next rising edge and are visible on csr_rdata_o in the following cycle. There is no write-to-read bypass.
- Reading mcycle/mcycleh returns the pre-increment value of the current cycle.
- redirect_* are purely combinational from ecall_i/mret_i and the stored mtvec/mepc.
  - An ecall in the cycle right after an mtvec write uses the new mtvec.
  - An mret in the same cycle as an mepc write uses the old mepc, and the write is dropped by priority.

## Structure
- Shared package/header `ysyx_25040101_csr_defs`:
  - CSR address constants.
  - mstatus bit indices MIE/MPIE/MPP.
  - mcause code ECALL_M = 11.
  - mvendorid/marchid constants.
- One sub-module, `ysyx_25040101_csr_cycle_counter`:
  - 64-bit counter.
  - Ports: clk_i, rst_i, wr_lo_i, wr_hi_i, wdata_i, count_o[63:0].
  - Owns the increment-suppress-on-write rule.
- The top level holds the remaining registers, the read mux, the illegal decode and the priority logic.

## Test plan
- Reset, then read 0x300/0x305/0xF11 → 32'h1800, 0, 32'h7973_7978; read 0x7C0 → rdata 0, illegal 1.
- Write mtvec 32'h8000_0103, then next cycle ecall with pc_i 32'h8000_0046:
  - redirect_pc_o = 32'h8000_0100.
  - Next cycle: mepc reads 32'h8000_0044, mcause reads 11, MIE reads 0.
- Set mstatus MIE via write 32'h8, ecall, then mret:
  - MPIE reads 1 after ecall.
  - After mret: MIE = 1, MPIE = 1; redirect_pc_o = mepc.
- Write mcycle 32'hFFFF_FFFF:
  - Next cycle mcycle reads FFFF_FFFF.
  - Following cycle: mcycle reads 0 and mcycleh reads 1.
- Assert ecall_i, mret_i and csr_we_i (addr 0x341, data 0x1234) together:
  - Only the ecall effect is applied; mepc = pc_i & ~3, not 0x1234.
  - redirect_pc_o = mtvec.
- Write 0xF11 with csr_we_i:
  - illegal 1.
  - Value unchanged next cycle.
  - rst_i pulsed mid-run clears mcycle and mepc immediately, without waiting for a clock edge.
